// File: rtl/id_ex_stage.sv
// ID->EX operand stage: register-file addressing, MEM/WB bypass, RAW hazard
// detection with bubble insertion, and the EX pipeline register.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [4:0]        id_rd,
    input  logic              id_regw,
    input  logic              id_memrd,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              mem_regw,
    input  logic              mem_memrd,
    input  logic [4:0]        mem_rd,
    input  logic [31:0]       mem_data,
    input  logic              wb_regw,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rd,
    output logic              ex_regw,
    output logic              ex_memrd,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [31:0] op1;
    logic [31:0] op2;
    logic        pend1;
    logic        pend2;
    logic        hazard;

    assign rf_rs1 = id_rs1;
    assign rf_rs2 = id_rs2;

    // A loaded value in MEM is not yet available, so it never bypasses;
    // WB bypass covers the RegFile returning the old value in its write cycle.
    function automatic logic [31:0] resolve(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        m_regw,
        input logic        m_memrd,
        input logic [4:0]  m_rd,
        input logic [31:0] m_data,
        input logic        w_regw,
        input logic [4:0]  w_rd,
        input logic [31:0] w_data
    );
        if (rs == 5'd0)
            return 32'd0;
        else if (m_regw && !m_memrd && m_rd == rs)
            return m_data;
        else if (w_regw && w_rd == rs)
            return w_data;
        else
            return rf_data;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op1 = 32'd0;
        op2 = 32'd0;
        op1 = resolve(id_rs1, rf_rd1, mem_regw, mem_memrd, mem_rd, mem_data,
                      wb_regw, wb_rd, wb_data);
        op2 = resolve(id_rs2, rf_rd2, mem_regw, mem_memrd, mem_rd, mem_data,
                      wb_regw, wb_rd, wb_data);
    end

    assign pend1 = (ex_valid && ex_regw && ex_rd == id_rs1) ||
                   (mem_regw && mem_memrd && mem_rd == id_rs1);
    assign pend2 = (ex_valid && ex_regw && ex_rd == id_rs2) ||
                   (mem_regw && mem_memrd && mem_rd == id_rs2);

    assign hazard = id_valid &&
                    ((id_use1 && id_rs1 != 5'd0 && pend1) ||
                     (id_use2 && id_rs2 != 5'd0 && pend2));

    assign id_stall = pipe_stall || (hazard && !flush);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= 32'd0;
            ex_rd      <= 5'd0;
            ex_regw    <= 1'b0;
            ex_memrd   <= 1'b0;
            ex_imm     <= 32'd0;
            ex_ctrl    <= '0;
            ex_op1     <= 32'd0;
            ex_op2     <= 32'd0;
            bubble_cnt <= '0;
        end else if (!pipe_stall) begin
            if (flush || hazard) begin
                // Bubble: only the qualifying bits clear, payload fields hold.
                ex_valid <= 1'b0;
                ex_regw  <= 1'b0;
                ex_memrd <= 1'b0;
                if (!flush && bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                ex_valid <= id_valid;
                ex_pc    <= id_pc;
                ex_rd    <= id_rd;
                ex_regw  <= id_regw;
                ex_memrd <= id_memrd;
                ex_imm   <= id_imm;
                ex_ctrl  <= id_ctrl;
                ex_op1   <= op1;
                ex_op2   <= op2;
            end
        end
    end

endmodule
